memory_v3: RTL and testbench

Parametrised successor to the memory unit: word-addressed data RAM plus a memory-mapped IO register bank in one address space.
- Generalised in data/address width, seven-segment digit count and input-synchroniser depth.
- Adds over the previous generation: registered one-cycle read with valid strobe, synchronised inputs, sticky button-edge capture, readable output registers, sticky error logging.
- Sits between core load/store stage and board IO.

---
 rtl/memory_v3_if.sv | 29 ++
 rtl/memory_v3.sv | 176 +++++++++++++++++
 tb/tb_memory_v3.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/memory_v3_if.sv
// memory_v3_if: load/store bus between the core and memory_v3.
//   mem_addr      word address (top bit selects IO space)
//   data_in       write data
//   write_enable  write strobe
//   read_enable   read strobe
//   data_out      registered read data
//   rd_valid      one-cycle pulse when data_out is updated
// Modports: master = core side, slave = memory_v3.
interface memory_v3_if #(
    parameter int addr_width = 10,
    parameter int data_width = 32
);
    logic [addr_width-1:0] mem_addr;
    logic [data_width-1:0] data_in;
    logic                  write_enable;
    logic                  read_enable;
    logic [data_width-1:0] data_out;
    logic                  rd_valid;

    modport master (
        output mem_addr, data_in, write_enable, read_enable,
        input  data_out, rd_valid
    );

    modport slave (
        input  mem_addr, data_in, write_enable, read_enable,
        output data_out, rd_valid
    );
endinterface

// File: rtl/memory_v3.sv
// memory_v3: word-addressed data RAM (lower half of the address space) plus a
// memory-mapped IO register bank (upper half, offset = mem_addr[3:0]).
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   bus (slave)         load/store bus, one-cycle registered reads
//   pmod_in/pmod_out    15-bit PMOD input (synchronised) / output register
//   button_array        4 async buttons, level + sticky rising-edge latch
//   switch_array        16 async switches
//   seg_out             n_seg digits, digit i at [7i+6:7i], active-low gfedcba
//   memory_error_vector sticky error flags (cleared by any write to 0xD)
// Build option: define SEG_HEX_DECODE_EN to store {enable, hex nibble} per
// digit and drive hex-decoded patterns instead of raw 7-bit segment patterns.
module memory_v3 #(
    parameter int addr_width  = 10,
    parameter int data_width  = 32,
    parameter int n_seg       = 8,
    parameter int sync_stages = 2
) (
    input  logic               clk,
    input  logic               rst,
    memory_v3_if.slave         bus,
    input  logic [14:0]        pmod_in,
    output logic [14:0]        pmod_out,
    input  logic [3:0]         button_array,
    input  logic [15:0]        switch_array,
    output logic [n_seg*7-1:0] seg_out,
    output logic [7:0]         memory_error_vector
);
    localparam int RAM_WORDS = 2 ** (addr_width - 1);
    localparam logic [3:0] NSEG4 = 4'(n_seg);
`ifdef SEG_HEX_DECODE_EN
    localparam int SEG_W = 5;
    localparam logic [SEG_W-1:0] SEG_RST = '0;  // digit disabled -> blank
`else
    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_RST = 7'h7F;
`endif

    // ---------------- input synchronisers ----------------
    logic [sync_stages-1:0][14:0] pmod_sync;
    logic [sync_stages-1:0][15:0] sw_sync;
    logic [sync_stages-1:0][3:0]  btn_sync;
    logic [14:0] pmod_s;
    logic [15:0] sw_s;
    logic [3:0]  btn_s, btn_d, btn_rise;

    assign pmod_s   = pmod_sync[sync_stages-1];
    assign sw_s     = sw_sync[sync_stages-1];
    assign btn_s    = btn_sync[sync_stages-1];
    assign btn_rise = btn_s & ~btn_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pmod_sync <= '0;
            sw_sync   <= '0;
            btn_sync  <= '0;
            btn_d     <= '0;
        end else begin
            pmod_sync <= {pmod_sync[sync_stages-2:0], pmod_in};
            sw_sync   <= {sw_sync[sync_stages-2:0], switch_array};
            btn_sync  <= {btn_sync[sync_stages-2:0], button_array};
            btn_d     <= btn_s;
        end
    end

    // ---------------- decode ----------------
    logic                  io_sel, upper_nz, collide, rd_go, any_acc;
    logic                  seg_hit, unmapped, ro_hit, err_clr;
    logic [3:0]            off;
    logic [addr_width-2:0] ram_idx;

    assign io_sel   = bus.mem_addr[addr_width-1];
    assign off      = bus.mem_addr[3:0];
    assign upper_nz = |bus.mem_addr[addr_width-2:4];
    assign ram_idx  = bus.mem_addr[addr_width-2:0];
    assign collide  = bus.write_enable & bus.read_enable;
    assign rd_go    = bus.read_enable & ~bus.write_enable;  // write wins
    assign any_acc  = bus.write_enable | bus.read_enable;
    // n_seg <= 8, so seg_hit alone also implies off < 8
    assign seg_hit  = (off < NSEG4);
    assign unmapped = (~off[3] & ~seg_hit) | (off == 4'hE) | (off == 4'hF);
    assign ro_hit   = (off == 4'h9) | (off == 4'hA) | (off == 4'hB);
    assign err_clr  = bus.write_enable & io_sel & (off == 4'hD);

    // ---------------- state ----------------
    logic [data_width-1:0]       ram [0:RAM_WORDS-1];
    logic [n_seg-1:0][SEG_W-1:0] seg_reg;
    logic [3:0]                  edge_lat;
    logic [7:0]                  err_new;
    logic [3:0]                  lat_clr;
    logic [SEG_W-1:0]            seg_rd;
    logic [data_width-1:0]       rd_mux;

    always_ff @(posedge clk) begin
        if (bus.write_enable && !io_sel)
            ram[ram_idx] <= bus.data_in;
    end

    always_comb begin
        err_new    = '0;
        err_new[0] = bus.write_enable & io_sel & ro_hit;
        err_new[1] = any_acc & io_sel & unmapped;
        err_new[2] = collide;
        err_new[3] = any_acc & io_sel & upper_nz;

        lat_clr = '0;
        if (io_sel && off == 4'hC) begin
            if (rd_go)                 lat_clr = 4'hF;
            else if (bus.write_enable) lat_clr = bus.data_in[3:0];
        end

        seg_rd = '0;
        for (int i = 0; i < n_seg; i++)
            if (off == 4'(i)) seg_rd = seg_reg[i];

        rd_mux = '0;
        if (!io_sel) begin
            rd_mux = ram[ram_idx];
        end else begin
            case (off)
                4'h8:    rd_mux[14:0] = pmod_out;
                4'h9:    rd_mux[14:0] = pmod_s;
                4'hA:    rd_mux[15:0] = sw_s;
                4'hB:    rd_mux[3:0]  = btn_s;
                4'hC:    rd_mux[3:0]  = edge_lat;
                4'hD:    rd_mux[7:0]  = memory_error_vector;
                default: if (seg_hit) rd_mux[SEG_W-1:0] = seg_rd;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.data_out        <= '0;
            bus.rd_valid        <= 1'b0;
            pmod_out            <= '0;
            memory_error_vector <= '0;
            edge_lat            <= '0;
            for (int i = 0; i < n_seg; i++) seg_reg[i] <= SEG_RST;
        end else begin
            bus.rd_valid <= rd_go;
            if (rd_go) bus.data_out <= rd_mux;

            if (bus.write_enable && io_sel && off == 4'h8)
                pmod_out <= bus.data_in[14:0];
            for (int i = 0; i < n_seg; i++)
                if (bus.write_enable && io_sel && off == 4'(i))
                    seg_reg[i] <= bus.data_in[SEG_W-1:0];

            // a new rising edge survives a same-cycle clear
            edge_lat <= (edge_lat & ~lat_clr) | btn_rise;
            // clear first, then OR in anything raised this cycle
            memory_error_vector <= (err_clr ? 8'h00 : memory_error_vector) | err_new;
        end
    end

    // ---------------- seven-segment drive ----------------
`ifdef SEG_HEX_DECODE_EN
    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h40; 4'h1: hex7 = 7'h79; 4'h2: hex7 = 7'h24; 4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19; 4'h5: hex7 = 7'h12; 4'h6: hex7 = 7'h02; 4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00; 4'h9: hex7 = 7'h10; 4'hA: hex7 = 7'h08; 4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46; 4'hD: hex7 = 7'h21; 4'hE: hex7 = 7'h06; default: hex7 = 7'h0E;
        endcase
    endfunction
`endif

    for (genvar g = 0; g < n_seg; g++) begin : g_seg
`ifdef SEG_HEX_DECODE_EN
        assign seg_out[7*g +: 7] = seg_reg[g][4] ? hex7(seg_reg[g][3:0]) : 7'h7F;
`else
        assign seg_out[7*g +: 7] = seg_reg[g];
`endif
    end
endmodule

// File: tb/tb_memory_v3.sv
module tb_memory_v3;
    localparam int AW = 10, DW = 32, NSEG = 6, SS = 2;
`ifdef SEG_HEX_DECODE_EN
    localparam logic [31:0] SEG_WR = 32'h1A, SEG_RB = 32'h1A, SEG_RST_RB = 32'h0;
    localparam logic [6:0]  SEG_EXP = 7'h08;
`else
    localparam logic [31:0] SEG_WR = 32'hFFFF_FF92, SEG_RB = 32'h12, SEG_RST_RB = 32'h7F;
    localparam logic [6:0]  SEG_EXP = 7'h12;
`endif

    logic clk = 0, rst = 0;
    logic [14:0] pmod_in, pmod_out;
    logic [3:0]  button_array;
    logic [15:0] switch_array;
    logic [NSEG*7-1:0] seg_out;
    logic [7:0]  memory_error_vector;

    memory_v3_if #(.addr_width(AW), .data_width(DW)) bus ();

    memory_v3 #(.addr_width(AW), .data_width(DW), .n_seg(NSEG), .sync_stages(SS)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .pmod_in(pmod_in), .pmod_out(pmod_out),
        .button_array(button_array), .switch_array(switch_array),
        .seg_out(seg_out), .memory_error_vector(memory_error_vector)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_dout = 0;

    // reference RAM for the random phase: 16-word pool at 0x100..0x10F
    logic [31:0] ram_m [16];
    bit          ram_v [16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // monitor: pop expected read data whenever rd_valid is presented
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst) begin
            last_dout = 0;
        end else if (bus.rd_valid) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected rd_valid: data_out=%0h", bus.data_out);
            end else begin
                e = exp_q.pop_front();
                chk("read data", bus.data_out, e);
            end
            last_dout = bus.data_out;
        end else begin
            chk("data_out hold", bus.data_out, last_dout);
        end
    end

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d);
        bus.mem_addr = a; bus.data_in = d;
        bus.write_enable = 1; bus.read_enable = 0;
        cycle();
        bus.write_enable = 0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [31:0] e);
        bus.mem_addr = a; bus.read_enable = 1; bus.write_enable = 0;
        exp_q.push_back(e);
        cycle();
        bus.read_enable = 0;
    endtask

    initial begin
        bus.mem_addr = 0; bus.data_in = 0; bus.write_enable = 0; bus.read_enable = 0;
        pmod_in = 0; button_array = 0; switch_array = 16'h1234;
        repeat (3) cycle();
        chk("reset data_out", bus.data_out, 0);
        chk("reset rd_valid", bus.rd_valid, 0);
        chk("reset pmod_out", pmod_out, 0);
        chk("reset err", memory_error_vector, 0);
        chk("reset seg", seg_out, {(NSEG*7){1'b1}});
        rst = 1;
        repeat (4) cycle();

        // RAM write then read, one-cycle valid pulse
        do_write(10'h005, 32'hDEADBEEF);
        do_read(10'h005, 32'hDEADBEEF);
        chk("rd_valid high", bus.rd_valid, 1);
        cycle();
        chk("rd_valid low", bus.rd_valid, 0);

        // seven-segment register and unmapped digit boundary (NSEG=6)
        do_write(10'h202, SEG_WR);
        chk("seg digit2", seg_out[20:14], SEG_EXP);
        do_read(10'h202, SEG_RB);
        do_read(10'h205, SEG_RST_RB);
        chk("err clean", memory_error_vector, 0);
        do_read(10'h206, 0);
        chk("err unmapped seg", memory_error_vector, 8'h02);
        do_write(10'h20D, 0);
        chk("err cleared", memory_error_vector, 0);

        // PMOD
        do_write(10'h208, 32'hFFFF_ABCD);
        chk("pmod_out", pmod_out, 15'h2BCD);
        do_read(10'h208, 32'h2BCD);
        pmod_in = 15'h1357;
        repeat (3) cycle();
        do_read(10'h209, 32'h1357);

        // button edge latch: pulse, read-clear
        button_array = 4'b0010;
        repeat (3) cycle();
        button_array = 0;
        repeat (4) cycle();
        do_read(10'h20C, 32'h2);
        do_read(10'h20C, 32'h0);
        // edge lands on the same edge as the clearing read: set wins
        button_array = 4'b1000;
        cycle(); cycle();
        do_read(10'h20C, 32'h0);
        do_read(10'h20C, 32'h8);
        do_read(10'h20C, 32'h0);
        do_read(10'h20B, 32'h8);
        button_array = 0;
        repeat (4) cycle();
        // write-1-to-clear only clears selected bits
        button_array = 4'b0001;
        repeat (5) cycle();
        do_write(10'h20C, 32'hE);
        do_read(10'h20C, 32'h1);
        button_array = 4'b0101;
        repeat (5) cycle();
        do_write(10'h20C, 32'h4);
        do_read(10'h20C, 32'h0);
        button_array = 0;
        chk("err after edges", memory_error_vector, 0);

        // write to read-only register
        do_write(10'h20A, 0);
        chk("err ro write", memory_error_vector, 8'h01);
        do_read(10'h20A, 32'h1234);
        do_write(10'h20D, 0);
        chk("err clear ro", memory_error_vector, 0);

        // non-zero upper IO offset bits; clear with a same-cycle new error
        do_read(10'h21A, 32'h1234);
        chk("err upper", memory_error_vector, 8'h08);
        do_write(10'h21D, 0);
        chk("err clear+set", memory_error_vector, 8'h08);
        do_write(10'h20D, 0);
        do_write(10'h20F, 5);
        chk("err unmapped F", memory_error_vector, 8'h02);
        do_write(10'h20D, 0);

        // collision: write done, read dropped
        bus.mem_addr = 10'h010; bus.data_in = 32'h55;
        bus.write_enable = 1; bus.read_enable = 1;
        cycle();
        bus.write_enable = 0; bus.read_enable = 0;
        chk("collision no valid", bus.rd_valid, 0);
        chk("err collision", memory_error_vector, 8'h04);
        do_read(10'h010, 32'h55);
        do_write(10'h20D, 0);

        // switch synchroniser latency
        switch_array = 16'hA5A5;
        do_read(10'h20A, 32'h1234);
        do_read(10'h20A, 32'h1234);
        do_read(10'h20A, 32'hA5A5);

        // random RAM traffic against the reference pool
        for (int i = 0; i < 200; i++) begin
            int k, op;
            k  = $urandom_range(0, 15);
            op = $urandom_range(0, 3);
            if (op == 0 || (op != 3 && !ram_v[k])) begin
                ram_m[k] = $urandom;
                ram_v[k] = 1;
                do_write(10'h100 + 10'(k), ram_m[k]);
            end else if (op != 3) begin
                do_read(10'h100 + 10'(k), ram_m[k]);
            end else begin
                cycle();
            end
        end
        chk("err after random", memory_error_vector, 0);

        // reset in the middle of a read
        do_write(10'h20E, 0);
        bus.mem_addr = 10'h005; bus.read_enable = 1;
        cycle();
        rst = 0;
        #1;
        chk("mid-reset rd_valid", bus.rd_valid, 0);
        chk("mid-reset data_out", bus.data_out, 0);
        chk("mid-reset pmod_out", pmod_out, 0);
        chk("mid-reset err", memory_error_vector, 0);
        chk("mid-reset seg", seg_out, {(NSEG*7){1'b1}});
        bus.read_enable = 0;
        cycle(); cycle();
        rst = 1;
        repeat (3) cycle();
        do_read(10'h202, SEG_RST_RB);
        do_read(10'h005, 32'hDEADBEEF);
        repeat (3) cycle();
        chk("queue drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
